// File: rtl/cpu_pkg.sv
// Shared types for the pipeline: datapath widths, memory-stage state and EX/MEM bundle.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  dest;
    logic              mem_wr;
    logic              wb_sel;
    logic              reg_wr;
    logic              call;
  } ex_mem_t;

  // A memory op needs word alignment; the low two address bits must be zero.
  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: state, timeout counter, dm_req, retire and error decode.
// Latency: dm_req rises the cycle after capture; retire is combinational on gnt/rvalid/timeout.
// Backpressure: holds REQ until dm_gnt, WAIT_RD until dm_rvalid, aborts after TIMEOUT_CYC cycles.
module mem_req_fsm
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic capture,
  input  logic cap_go,
  input  logic s1_valid,
  input  logic s1_mem_op,
  input  logic s1_misal,
  input  logic s1_store,
  input  logic dm_gnt,
  input  logic dm_rvalid,
  output logic dm_req,
  output logic retire,
  output logic ret_err,
  output logic ret_load
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done_st;
  logic             timeout;
  logic             idle_ret;
  logic             idle_err;

  // Retire decode; in REQ a same-cycle rvalid is ignored because only WAIT_RD looks at it.
  always_comb begin
    busy     = (state != IDLE);
    done_st  = (state == REQ) && dm_gnt && s1_store;
    ret_load = (state == WAIT_RD) && dm_rvalid;
    timeout  = busy && (cnt == CNT_MAX) && !done_st && !ret_load;
    // A valid op sitting in IDLE was captured last edge: either non-memory or a misaligned access.
    idle_ret = (state == IDLE) && s1_valid && (!s1_mem_op || s1_misal);
    idle_err = (state == IDLE) && s1_valid && s1_mem_op && s1_misal;
    retire   = idle_ret || done_st || ret_load || timeout;
    ret_err  = idle_err || timeout;
  end

  // State, timeout counter and registered dm_req; a new capture wins over the old op's retire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dm_req <= 1'b0;
    end else if (capture && cap_go) begin
      state  <= REQ;
      cnt    <= '0;
      dm_req <= 1'b1;
    end else if (retire) begin
      state  <= IDLE;
      cnt    <= '0;
      dm_req <= 1'b0;
    end else if ((state == REQ) && dm_gnt) begin
      state  <= WAIT_RD;
      cnt    <= cnt + 1'b1;
      dm_req <= 1'b0;
    end else if (busy) begin
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM latch, data-memory handshake, MEM/WB register and ALU forwarding.
// Latency: ALU op 1 cycle after capture; store adds gnt wait; load adds gnt and rvalid waits.
// Backpressure: stall_out holds execute while the captured op has not retired.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [REG_W-1:0]  reg_dest_in,
  input  logic              mem_wr_in,
  input  logic              wb_sel_in,
  input  logic              reg_wr_in,
  input  logic              call_in,
  output logic              stall_out,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dest,
  output logic              wb_reg_wr,
  output logic              wb_call,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic              err
);

  ex_mem_t s1;
  logic    s1_valid;
  logic    s1_mem_op;
  logic    s1_misal;
  logic    capture;
  logic    cap_go;
  logic    retire;
  logic    ret_err;
  logic    ret_load;

  // Stall, capture qualification and the memory/forward views of S1.
  always_comb begin
    s1_mem_op = s1.mem_wr || s1.wb_sel;
    s1_misal  = is_misaligned(s1.addr);
    stall_out = s1_valid && !retire;
    capture   = !stall_out;
    cap_go    = ex_valid && (mem_wr_in || wb_sel_in) && !is_misaligned(mem_addr_in);
    dm_we     = s1.mem_wr;
    dm_addr   = s1.addr;
    dm_wdata  = s1.wdata;
    fwd_en    = s1_valid && s1.reg_wr && !s1.wb_sel;
    fwd_dest  = s1.dest;
    fwd_data  = s1.alu;
  end

  mem_req_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .cap_go    (cap_go),
    .s1_valid  (s1_valid),
    .s1_mem_op (s1_mem_op),
    .s1_misal  (s1_misal),
    .s1_store  (s1.mem_wr),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_req    (dm_req),
    .retire    (retire),
    .ret_err   (ret_err),
    .ret_load  (ret_load)
  );

  // EX/MEM register: loads whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= '0;
      s1_valid <= 1'b0;
    end else if (capture) begin
      s1.addr   <= mem_addr_in;
      s1.wdata  <= mem_data_in;
      s1.alu    <= alu_in;
      s1.dest   <= reg_dest_in;
      s1.mem_wr <= mem_wr_in;
      s1.wb_sel <= wb_sel_in;
      s1.reg_wr <= reg_wr_in;
      s1.call   <= call_in;
      s1_valid  <= ex_valid;
    end
  end

  // MEM/WB register: one-cycle retire pulse; stores and errored ops never write a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_dest   <= '0;
      wb_reg_wr <= 1'b0;
      wb_call   <= 1'b0;
      err       <= 1'b0;
    end else if (retire) begin
      wb_valid  <= 1'b1;
      wb_data   <= ret_load ? dm_rdata : s1.alu;
      wb_dest   <= s1.dest;
      wb_reg_wr <= s1.reg_wr && !s1.mem_wr && !ret_err;
      wb_call   <= s1.call;
      err       <= ret_err;
    end else begin
      wb_valid  <= 1'b0;
      wb_reg_wr <= 1'b0;
      err       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, store, load, misaligned, timeout and mid-access reset.
// Latency: checks each cycle 1 ns after the rising edge, combinational outputs after input drive.
// Backpressure: dm_gnt/dm_rvalid driven by hand to exercise every wait state.
module tb_mem_stage;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid;
  logic [DATA_W-1:0] mem_addr_in;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] alu_in;
  logic [REG_W-1:0]  reg_dest_in;
  logic              mem_wr_in;
  logic              wb_sel_in;
  logic              reg_wr_in;
  logic              call_in;
  logic              stall_out;
  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_dest;
  logic              wb_reg_wr;
  logic              wb_call;
  logic              fwd_en;
  logic [REG_W-1:0]  fwd_dest;
  logic [DATA_W-1:0] fwd_data;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .mem_addr_in (mem_addr_in),
    .mem_data_in (mem_data_in),
    .alu_in      (alu_in),
    .reg_dest_in (reg_dest_in),
    .mem_wr_in   (mem_wr_in),
    .wb_sel_in   (wb_sel_in),
    .reg_wr_in   (reg_wr_in),
    .call_in     (call_in),
    .stall_out   (stall_out),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_gnt      (dm_gnt),
    .dm_rvalid   (dm_rvalid),
    .dm_rdata    (dm_rdata),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_dest     (wb_dest),
    .wb_reg_wr   (wb_reg_wr),
    .wb_call     (wb_call),
    .fwd_en      (fwd_en),
    .fwd_dest    (fwd_dest),
    .fwd_data    (fwd_data),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction from execute.
  task automatic drive(input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] alu,
                       input logic [3:0] dest, input logic wr, input logic sel,
                       input logic rw, input logic cl);
    ex_valid    = 1'b1;
    mem_addr_in = addr;
    mem_data_in = wdat;
    alu_in      = alu;
    reg_dest_in = dest;
    mem_wr_in   = wr;
    wb_sel_in   = sel;
    reg_wr_in   = rw;
    call_in     = cl;
  endtask

  task automatic bubble();
    ex_valid  = 1'b0;
    mem_wr_in = 1'b0;
    wb_sel_in = 1'b0;
    reg_wr_in = 1'b0;
    call_in   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    mem_addr_in = '0; mem_data_in = '0; alu_in = '0; reg_dest_in = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_dm_req", 32'(dm_req), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_fwd_en", 32'(fwd_en), 0);
    rst_n = 1'b1;
    tick();

    // ALU op: forward next cycle, writeback the cycle after, no stall
    drive(32'h0, 32'h0, 32'h1234, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); bubble(); #1;
    chk("alu_fwd_en", 32'(fwd_en), 1);
    chk("alu_fwd_data", fwd_data, 32'h1234);
    chk("alu_fwd_dest", 32'(fwd_dest), 3);
    chk("alu_stall", 32'(stall_out), 0);
    chk("alu_dm_req", 32'(dm_req), 0);
    tick();
    chk("alu_wb_valid", 32'(wb_valid), 1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_dest", 32'(wb_dest), 3);
    chk("alu_wb_reg_wr", 32'(wb_reg_wr), 1);
    chk("alu_wb_call", 32'(wb_call), 1);
    chk("alu_err", 32'(err), 0);
    tick();
    chk("alu_wb_pulse", 32'(wb_valid), 0);

    // Store to 0x40, gnt in third request cycle
    drive(32'h40, 32'hDEADBEEF, 32'h40, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); bubble(); #1;
    chk("st_req_c1", 32'(dm_req), 1);
    chk("st_we", 32'(dm_we), 1);
    chk("st_addr", dm_addr, 32'h40);
    chk("st_wdata", dm_wdata, 32'hDEADBEEF);
    chk("st_stall_c1", 32'(stall_out), 1);
    chk("st_fwd_en", 32'(fwd_en), 1);
    tick();
    chk("st_req_c2", 32'(dm_req), 1);
    chk("st_addr_c2", dm_addr, 32'h40);
    chk("st_stall_c2", 32'(stall_out), 1);
    tick();
    dm_gnt = 1'b1; #1;
    chk("st_req_c3", 32'(dm_req), 1);
    chk("st_stall_c3", 32'(stall_out), 0);
    tick();
    dm_gnt = 1'b0; #1;
    chk("st_wb_valid", 32'(wb_valid), 1);
    chk("st_wb_reg_wr", 32'(wb_reg_wr), 0);
    chk("st_wb_dest", 32'(wb_dest), 5);
    chk("st_req_drop", 32'(dm_req), 0);
    chk("st_err", 32'(err), 0);

    // Load from 0x80: gnt at once, rvalid three cycles later
    drive(32'h80, 32'h0, 32'h80, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); bubble();
    dm_gnt = 1'b1; #1;
    chk("ld_req", 32'(dm_req), 1);
    chk("ld_we", 32'(dm_we), 0);
    chk("ld_addr", dm_addr, 32'h80);
    chk("ld_stall_c1", 32'(stall_out), 1);
    chk("ld_no_fwd", 32'(fwd_en), 0);
    tick();
    dm_gnt = 1'b0; #1;
    chk("ld_req_drop", 32'(dm_req), 0);
    chk("ld_stall_c2", 32'(stall_out), 1);
    tick();
    chk("ld_stall_c3", 32'(stall_out), 1);
    chk("ld_wb_wait", 32'(wb_valid), 0);
    tick();
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFEF00D; #1;
    chk("ld_stall_c4", 32'(stall_out), 0);
    tick();
    dm_rvalid = 1'b0; dm_rdata = '0; #1;
    chk("ld_wb_valid", 32'(wb_valid), 1);
    chk("ld_wb_data", wb_data, 32'hCAFEF00D);
    chk("ld_wb_dest", 32'(wb_dest), 7);
    chk("ld_wb_reg_wr", 32'(wb_reg_wr), 1);
    chk("ld_err", 32'(err), 0);

    // Misaligned load 0x82: no request, error retire next cycle
    drive(32'h82, 32'h0, 32'h82, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); bubble(); #1;
    chk("mis_req", 32'(dm_req), 0);
    chk("mis_stall", 32'(stall_out), 0);
    tick();
    chk("mis_req_c2", 32'(dm_req), 0);
    chk("mis_err", 32'(err), 1);
    chk("mis_wb_valid", 32'(wb_valid), 1);
    chk("mis_wb_reg_wr", 32'(wb_reg_wr), 0);
    tick();
    chk("mis_err_pulse", 32'(err), 0);

    // Load at 0x100 never granted: abort in the 16th waiting cycle
    drive(32'h100, 32'h0, 32'h100, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); bubble(); #1;
    for (int i = 0; i < 15; i++) begin
      chk("to_req_held", 32'(dm_req), 1);
      chk("to_stall_held", 32'(stall_out), 1);
      tick();
    end
    chk("to_req_last", 32'(dm_req), 1);
    chk("to_stall_last", 32'(stall_out), 0);
    tick();
    chk("to_err", 32'(err), 1);
    chk("to_wb_valid", 32'(wb_valid), 1);
    chk("to_wb_reg_wr", 32'(wb_reg_wr), 0);
    chk("to_req_drop", 32'(dm_req), 0);
    // late gnt/rvalid must be ignored
    dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h11111111; #1;
    chk("late_stall", 32'(stall_out), 0);
    tick();
    dm_gnt = 1'b0; dm_rvalid = 1'b0; #1;
    chk("late_wb_valid", 32'(wb_valid), 0);
    chk("late_err", 32'(err), 0);
    chk("late_req", 32'(dm_req), 0);
    // following op proceeds normally
    drive(32'h0, 32'h0, 32'h55, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); bubble(); #1;
    chk("post_stall", 32'(stall_out), 0);
    tick();
    chk("post_wb_valid", 32'(wb_valid), 1);
    chk("post_wb_data", wb_data, 32'h55);
    chk("post_wb_dest", 32'(wb_dest), 2);
    chk("post_err", 32'(err), 0);

    // Reset during WAIT_RD
    drive(32'hC0, 32'h0, 32'hC0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(); bubble();
    dm_gnt = 1'b1; #1;
    chk("rw_req", 32'(dm_req), 1);
    tick();
    dm_gnt = 1'b0; #1;
    chk("rw_stall", 32'(stall_out), 1);
    rst_n = 1'b0;
    tick();
    chk("rw_req_rst", 32'(dm_req), 0);
    chk("rw_wb_rst", 32'(wb_valid), 0);
    chk("rw_stall_rst", 32'(stall_out), 0);
    rst_n = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'h22222222;
    tick();
    dm_rvalid = 1'b0; #1;
    chk("rw_stale_rv", 32'(wb_valid), 0);
    tick();
    chk("rw_stale_rv2", 32'(wb_valid), 0);
    chk("rw_err", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

endmodule
